ctrl_fsm_param: RTL

Parametrised multicycle instruction controller for the 32-bit CPU datapath. It fetches and latches one instruction word, then sequences it through execute, memory and write-back, driving the register file, ALU function select, data memory and program counter. Compared with the fixed controller it adds:
- configurable field widths;
- a latched instruction register;
- a ready handshake with data memory;
- jump support;
- a retired-instruction counter.

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/ctrl_decode.sv | 84 ++++++++
 rtl/ctrl_fsm_param.sv | 109 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle instruction controller.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF,
    S_EX,
    S_ME,
    S_WB,
    S_WB_M
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  localparam logic [1:0] CLS_REG = 2'b00;
  localparam logic [1:0] CLS_IMM = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_JMP = 2'b11;

  localparam logic [5:0] SUB_ST = 6'd0;
  localparam logic [5:0] SUB_LD = 6'd1;

  localparam logic [1:0] DM_CLR  = 2'b00;
  localparam logic [1:0] DM_IDLE = 2'b01;
  localparam logic [1:0] DM_LD   = 2'b10;
  localparam logic [1:0] DM_ST   = 2'b11;

  localparam logic [1:0] PC_CLR  = 2'b00;
  localparam logic [1:0] PC_HOLD = 2'b01;
  localparam logic [1:0] PC_OUT  = 2'b10;
  localparam logic [1:0] PC_INC  = 2'b11;

  localparam logic [1:0] FN_REG = 2'b00;
  localparam logic [1:0] FN_IMM = 2'b01;
  localparam logic [1:0] FN_MEM = 2'b10;

  function automatic logic is_mem_subop(input logic [5:0] sub);
    return (sub == SUB_ST) || (sub == SUB_LD);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of controller state + latched instruction into datapath controls.
// Honours CTRL_ILLEGAL_TRAP_EN (adds the TRAP state decode).
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 24,
  parameter int IMM_W   = 8
) (
  input  state_t             state,
  input  logic [INSTR_W-1:0] ir,
  input  logic               run,
  output logic [1:0]         en_dm,
  output logic [ADDR_W-1:0]  addr,
  output logic [IMM_W-1:0]   imm_in,
  output logic               en_rg,
  output logic [1:0]         func,
  output logic [1:0]         en_pc,
  output logic               pc_load,
  output logic [5:0]         opcode,
  output logic               trap
);

  logic [1:0]        cls;
  logic [5:0]        sub;
  logic [ADDR_W-1:0] afield;

  assign cls    = ir[1:0];
  assign sub    = ir[7:2];
  assign afield = ir[ADDR_W+7:8];

  always_comb begin
    en_dm   = DM_CLR;
    addr    = '0;
    imm_in  = '0;
    en_rg   = 1'b0;
    func    = FN_REG;
    en_pc   = PC_HOLD;
    pc_load = 1'b0;
    opcode  = '0;
    trap    = 1'b0;
    case (state)
      // PC is only presented while fetching is live, not straight after reset/disable
      S_IF: en_pc = run ? PC_OUT : PC_HOLD;
      S_EX: begin
        func   = cls;
        opcode = sub;
        addr   = afield;
        en_rg  = 1'b1;
        if (cls == CLS_IMM) imm_in = ir[INSTR_W-1 -: IMM_W];
      end
      S_ME: begin
        func = FN_MEM;
        addr = afield;
        if (sub == SUB_ST) begin
          en_dm = DM_ST;
        end else if (sub == SUB_LD) begin
          en_dm = DM_LD;
          en_rg = 1'b1;
        end else begin
          en_dm = DM_IDLE;
        end
      end
      S_WB, S_WB_M: begin
        if (cls == CLS_JMP) begin
          pc_load = 1'b1;
          en_pc   = PC_HOLD;
          addr    = afield;
        end else begin
          en_pc = PC_INC;
        end
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        trap  = 1'b1;
        en_pc = PC_HOLD;
        en_dm = DM_IDLE;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm_param.sv
// Parametrised multicycle controller: IF/EX/ME/WB sequencing, instruction register, retired counter.
// CTRL_ILLEGAL_TRAP_EN: undefined memory subops lock into TRAP instead of retiring as a NOP.
module ctrl_fsm_param
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 24,
  parameter int IMM_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [INSTR_W-1:0] code,
  input  logic               mem_ready,
  output logic [1:0]         en_dm,
  output logic [ADDR_W-1:0]  addr,
  output logic [IMM_W-1:0]   imm_in,
  output logic               en_rg,
  output logic [1:0]         func,
  output logic [1:0]         en_pc,
  output logic               pc_load,
  output logic [5:0]         opcode,
  output logic [CNT_W-1:0]   retired,
  output logic               trap
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic               run_q;
  logic [CNT_W-1:0]   retired_q;
  logic               trapped;
  logic               retire;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trapped = (state_q == S_TRAP);
`else
  assign trapped = 1'b0;
`endif

  assign retire = enable && ((state_q == S_WB) || (state_q == S_WB_M));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      ir_q      <= '0;
      run_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= enable;
      if ((state_q == S_IF) && enable) ir_q <= code;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (enable) begin
          case (code[1:0])
            CLS_REG, CLS_IMM: state_d = S_EX;
            CLS_MEM:          state_d = S_ME;
            default:          state_d = S_WB;
          endcase
        end
      end
      S_EX: state_d = S_WB;
      S_ME: begin
        if (is_mem_subop(ir_q[7:2])) begin
          if (mem_ready) state_d = (ir_q[7:2] == SUB_LD) ? S_WB_M : S_WB;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_WB;
`endif
        end
      end
      S_WB, S_WB_M: state_d = S_IF;
      default: state_d = state_q;
    endcase
    // disable abandons the instruction from any state except a latched trap
    if (!enable && !trapped) state_d = S_IF;
  end

  ctrl_decode #(
    .INSTR_W(INSTR_W),
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_decode (
    .state  (state_q),
    .ir     (ir_q),
    .run    (run_q),
    .en_dm  (en_dm),
    .addr   (addr),
    .imm_in (imm_in),
    .en_rg  (en_rg),
    .func   (func),
    .en_pc  (en_pc),
    .pc_load(pc_load),
    .opcode (opcode),
    .trap   (trap)
  );

  assign retired = retired_q;

endmodule
